fire_scheduler: RTL
===================

# fire_scheduler

Synthesizable scheduler that drives the `fire` transition-select bus of a synchronous circuit model under test. It watches which transitions are currently excited and picks exactly one per clock cycle to fire. Selection is round-robin or fixed-priority with a starvation override. It also reports quiescence when no transition has been excited for a programmable number of cycles. The spec-compliance monitor checks `fire` against the same encoding, so this block replaces free `fire` stimulus in simulation and in bounded-liveness formal runs.

## Interface

**Parameters**
- `NTRANS`, default 8: number of schedulable transitions (inputs plus stateful gates).
- `FW`, default 4: width of `fire`. Must satisfy 2^FW > NTRANS+1.
- `MAX_WAIT`, default 15: starvation bound in cycles (≥1).
- `QUIET_CYCLES`, default 4: consecutive non-excited cycles that declare quiescence (≥1).

**Ports**
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `reset` — input, 1 — asynchronous, active-high reset.
- `excited` — input, NTRANS — bit i high means transition i is enabled in the current state.
- `mode` — input, 1 — 0 selects round-robin; 1 selects fixed priority (lowest index wins).
- `hold` — input, 1 — freezes scheduling; while high, no transition fires.
- `fire` — output, FW — registered index of the transition to fire (0..NTRANS-1), or IDLE = NTRANS+1.
- `fire_valid` — output, 1 — high when `fire` ≠ IDLE.
- `quiescent` — output, 1 — high in the QUIET state.
- `starve_err` — output, 1 — sticky; set when a transition at `MAX_WAIT` is excited but not granted.

## Operation

**State machine**, one-hot or encoded; states RUN, QUIET, HOLD.
- Reset → RUN.
- Any state with `hold`=1 → HOLD.
- HOLD with `hold`=0 → RUN, and the quiet counter is cleared.
- RUN with `excited`=0 for QUIET_CYCLES consecutive sampled cycles → QUIET.
- QUIET with `excited`≠0 → RUN, and a grant is issued in that same transition.

**Grant selection** (RUN, or QUIET leaving on nonzero `excited`):
- Candidates are the set bits of `excited`.
- Override: if any candidate has `wait[i]` == MAX_WAIT, grant the lowest such i.
- Otherwise, with `mode`=0, grant the first candidate at or after `ptr+1`, searching cyclically modulo NTRANS.
- Otherwise, with `mode`=1, grant the lowest-index candidate.
- With no candidates, `fire` = IDLE.
- On any grant, `ptr` ← granted index. The override also updates `ptr`.

**Wait counters** (NTRANS counters, each clog2(MAX_WAIT+1) bits):
- Cleared when the transition is granted or not excited.
- Incremented when excited and not granted, saturating at MAX_WAIT.
- Frozen in HOLD.
- `starve_err` sets when more than one candidate is at MAX_WAIT, since only one can be granted. It clears only on reset.

**Other rules**
- `ptr` and the wait counters are retained across HOLD and QUIET.
- The quiet counter saturates at QUIET_CYCLES and clears on any nonzero `excited` or on HOLD.
- The value NTRANS is never driven on `fire`; only 0..NTRANS-1 and NTRANS+1 appear.

## Timing

- `excited` is sampled at rising edge t. The resulting `fire` is valid from just after edge t until edge t+1, so latency is 1 cycle.
- `fire` is a pure register output, constant across the whole cycle, so negedge sampling equals the posedge value.
- A stale grant, where the granted transition is no longer excited when the circuit consumes it, is legal and has no effect.
- `hold` sampled high at edge t → `fire` = IDLE from edge t. The first grant after `hold` falls appears 1 cycle after it is sampled low.
- **Reset values:** `fire` = NTRANS+1; `fire_valid`=0; `quiescent`=0; `starve_err`=0; `ptr` = NTRANS-1, so the first round-robin grant is index 0; all counters 0; state RUN.
- Reset asserted mid-operation forces all of the above immediately, without waiting for a clock edge.

## Test plan

All scenarios use NTRANS=4, FW=3, MAX_WAIT=3, QUIET_CYCLES=2; IDLE = 5.

- **Reset:** `reset` pulse mid-run → `fire`=5, `fire_valid`=0, `quiescent`=0, `starve_err`=0, asynchronously, before the next clock edge.
- **Round-robin:** `mode`=0, `excited`=4'b1111 held → `fire` sequence 0,1,2,3,0,1; `starve_err` stays 0.
- **Starvation override:** `mode`=1, `excited`=4'b0011 → `fire` repeats 0,0,0,1; `starve_err` stays 0.
- **Starvation error:** `mode`=1, `excited`=4'b0111 → `fire` 0,0,0,1, and `starve_err` rises with the grant of 1 and stays high.
- **Quiescence:** `excited`=0 for 2 cycles → `quiescent`=1 and `fire`=5. Then `excited`=4'b0100 → next cycle `quiescent`=0 and `fire`=2.
- **Hold:** `mode`=0, `excited`=4'b1111, `hold` high for 2 cycles after grants 0,1 → `fire` 0,1,5,5,2,3, showing the pointer is preserved.

Source files
------------

// File: rtl/fire_scheduler.sv
// Picks one excited transition per cycle (round-robin or fixed priority with starvation override) onto a registered fire bus.
// One cycle from excited sampling to fire; hold forces IDLE from the sampling edge and freezes pointer and wait counters.
module fire_scheduler #(
  parameter int NTRANS       = 8,
  parameter int FW           = 4,
  parameter int MAX_WAIT     = 15,
  parameter int QUIET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NTRANS-1:0] excited,
  input  logic              mode,
  input  logic              hold,
  output logic [FW-1:0]     fire,
  output logic              fire_valid,
  output logic              quiescent,
  output logic              starve_err
);

  localparam int PW = (NTRANS > 1) ? $clog2(NTRANS) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [FW-1:0] IDLE = FW'(NTRANS + 1);

  typedef enum logic [1:0] {RUN, QUIET, HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] wait_q [NTRANS];
  logic [WW-1:0] wait_d [NTRANS];
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [FW-1:0] fire_q, fire_d;
  logic          err_q, err_d;

  logic          ovr_vld, multi, rr_vld, gnt_vld;
  logic [PW-1:0] ovr_idx, rr_idx, pr_idx, gnt_idx;

  always_comb begin
    ovr_vld = 1'b0;
    ovr_idx = '0;
    multi   = 1'b0;
    rr_vld  = 1'b0;
    rr_idx  = '0;
    pr_idx  = '0;
    for (int i = 0; i < NTRANS; i++) begin
      if (excited[i] && (wait_q[i] == WW'(MAX_WAIT))) begin
        if (ovr_vld) multi = 1'b1;
        else begin
          ovr_vld = 1'b1;
          ovr_idx = PW'(i);
        end
      end
    end
    // Cyclic search starting just after the last granted index
    for (int k = 1; k <= NTRANS; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NTRANS;
      if (!rr_vld && excited[j]) begin
        rr_vld = 1'b1;
        rr_idx = PW'(j);
      end
    end
    for (int i = NTRANS - 1; i >= 0; i--) begin
      if (excited[i]) pr_idx = PW'(i);
    end
    gnt_vld = |excited;
    gnt_idx = ovr_vld ? ovr_idx : (mode ? pr_idx : rr_idx);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    qcnt_d  = qcnt_q;
    fire_d  = IDLE;
    err_d   = err_q;
    if (hold) begin
      state_d = HOLD;
      qcnt_d  = '0;
    end else begin
      if (gnt_vld) begin
        fire_d = FW'(gnt_idx);
        ptr_d  = gnt_idx;
        if (multi) err_d = 1'b1;
      end
      for (int i = 0; i < NTRANS; i++) begin
        if (excited[i] && !(gnt_vld && (gnt_idx == PW'(i)))) begin
          wait_d[i] = (wait_q[i] == WW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + WW'(1);
        end else begin
          wait_d[i] = '0;
        end
      end
      if (|excited || (state_q == HOLD)) begin
        qcnt_d  = '0;
        state_d = RUN;
      end else begin
        qcnt_d = (qcnt_q == QW'(QUIET_CYCLES)) ? qcnt_q : qcnt_q + QW'(1);
        if (qcnt_q >= QW'(QUIET_CYCLES - 1)) state_d = QUIET;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= PW'(NTRANS - 1);
      qcnt_q  <= '0;
      fire_q  <= IDLE;
      err_q   <= 1'b0;
      for (int i = 0; i < NTRANS; i++) wait_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      qcnt_q  <= qcnt_d;
      fire_q  <= fire_d;
      err_q   <= err_d;
      for (int i = 0; i < NTRANS; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign fire       = fire_q;
  assign fire_valid = (fire_q != IDLE);
  assign quiescent  = (state_q == QUIET);
  assign starve_err = err_q;

endmodule
